// File: rtl/nv_nvdla_cdp_mcif_pkg.sv
// Shared constants and types for the CDP MCIF read responder.
package nv_nvdla_cdp_mcif_pkg;

    localparam int unsigned ATOM_BYTES   = 32;
    localparam int unsigned ATOM_SHIFT   = $clog2(ATOM_BYTES);
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned SIZE_W       = 15;
    localparam int unsigned DATA_W       = 256;

    // Request pd layout: {size, addr}
    localparam int unsigned REQ_ADDR_LSB = 0;
    localparam int unsigned REQ_SIZE_LSB = ADDR_W;
    localparam int unsigned REQ_PD_W     = SIZE_W + ADDR_W;

    // Response pd layout: {mask, data}
    localparam int unsigned MASK_BIT     = DATA_W;
    localparam int unsigned RSP_PD_W     = DATA_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/nv_nvdla_cdp_mcif_rsp_fifo.sv
// Flop-based synchronous FIFO buffering returned memory atoms.
module nv_nvdla_cdp_mcif_rsp_fifo #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    // Data storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/nv_nvdla_cdp_mcif_rd_responder.sv
// Memory-side responder: splits CDP read requests into atom reads,
// buffers returned atoms and returns them under latency-fifo credit control.
module nv_nvdla_cdp_mcif_rd_responder
    import nv_nvdla_cdp_mcif_pkg::*;
#(
    parameter int unsigned ADDR_W     = nv_nvdla_cdp_mcif_pkg::ADDR_W,
    parameter int unsigned SIZE_W     = nv_nvdla_cdp_mcif_pkg::SIZE_W,
    parameter int unsigned DATA_W     = nv_nvdla_cdp_mcif_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CDT_DEPTH  = 8
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic                         cdp2mcif_rd_req_valid,
    output logic                         cdp2mcif_rd_req_ready,
    input  logic [SIZE_W+ADDR_W-1:0]     cdp2mcif_rd_req_pd,
    output logic                         mcif2cdp_rd_rsp_valid,
    input  logic                         mcif2cdp_rd_rsp_ready,
    output logic [DATA_W:0]              mcif2cdp_rd_rsp_pd,
    input  logic                         cdp2mcif_rd_cdt_lat_fifo_pop,
    output logic                         mem_rd_en,
    output logic [ADDR_W-ATOM_SHIFT-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]            mem_rd_data,
    output logic                         cdt_overflow
);

    localparam int unsigned AW    = ADDR_W - ATOM_SHIFT;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = $clog2(CDT_DEPTH + 1);
    localparam logic [CNT_W:0]   FIFO_SPACE = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CRD_W-1:0] CRD_MAX    = CRD_W'(CDT_DEPTH);

    rd_state_e         state;
    logic [AW-1:0]     atom_addr;
    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] beat;
    logic              inflight;
    logic [CRD_W-1:0]  credits;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W:0]    occupancy;
    logic              rsp_hs;
    logic              unused_addr_lsb;

    // Sub-atom byte offset carries no meaning for atom-granular reads
    assign unused_addr_lsb = ^cdp2mcif_rd_req_pd[REQ_ADDR_LSB +: ATOM_SHIFT];

    // Issue gating: buffered plus in-flight atoms must leave room for one more
    always_comb begin
        occupancy   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight};
        mem_rd_en   = (state == BURST) && (occupancy < FIFO_SPACE);
        mem_rd_addr = atom_addr + AW'(beat);
    end

    // Response side: present FIFO head while credits remain
    always_comb begin
        mcif2cdp_rd_rsp_valid = !fifo_empty && (credits != '0);
        mcif2cdp_rd_rsp_pd    = {1'b1, fifo_head};
        rsp_hs                = mcif2cdp_rd_rsp_valid && mcif2cdp_rd_rsp_ready;
    end

    // Request FSM with beat/address counters and registered req_ready
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state                 <= IDLE;
            cdp2mcif_rd_req_ready <= 1'b1;
            atom_addr             <= '0;
            size_q                <= '0;
            beat                  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cdp2mcif_rd_req_valid) begin
                        atom_addr             <= cdp2mcif_rd_req_pd[REQ_ADDR_LSB+ATOM_SHIFT +: AW];
                        size_q                <= cdp2mcif_rd_req_pd[ADDR_W +: SIZE_W];
                        beat                  <= '0;
                        state                 <= BURST;
                        cdp2mcif_rd_req_ready <= 1'b0;
                    end
                end
                BURST: begin
                    if (mem_rd_en) begin
                        beat <= beat + SIZE_W'(1);
                        if (beat == size_q) begin
                            state                 <= IDLE;
                            cdp2mcif_rd_req_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory data arrives one cycle after the strobe
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) inflight <= 1'b0;
        else                inflight <= mem_rd_en;
    end

    // Credit counter and sticky overflow flag
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            credits      <= CRD_MAX;
            cdt_overflow <= 1'b0;
        end else begin
            if (rsp_hs && !cdp2mcif_rd_cdt_lat_fifo_pop) begin
                credits <= credits - CRD_W'(1);
            end else if (!rsp_hs && cdp2mcif_rd_cdt_lat_fifo_pop) begin
                if (credits == CRD_MAX) cdt_overflow <= 1'b1;
                else                    credits <= credits + CRD_W'(1);
            end
        end
    end

    nv_nvdla_cdp_mcif_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (nvdla_core_clk),
        .rst       (nvdla_core_rst),
        .push      (inflight),
        .push_data (mem_rd_data),
        .pop       (rsp_hs),
        .head      (fifo_head),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full_unused)
    );

endmodule

// File: tb/tb_nv_nvdla_cdp_mcif_rd_responder.sv
// Directed bench for the CDP MCIF read responder with an address/data scoreboard.
module tb_nv_nvdla_cdp_mcif_rd_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [46:0]  req_pd;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [256:0] rsp_pd;
    logic         cdt_pop;
    logic         mem_rd_en;
    logic [26:0]  mem_rd_addr;
    logic [255:0] mem_rd_data;
    logic         cdt_overflow;

    logic         man_pop;
    logic         auto_pop;
    logic         hs_d = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_rsp   = 0;
    int exp_credits = 8;
    bit exp_ovf = 1'b0;

    logic [26:0]  exp_addr_q[$];
    logic [256:0] exp_rsp_q[$];

    always #5 clk = ~clk;

    nv_nvdla_cdp_mcif_rd_responder dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .cdp2mcif_rd_req_valid        (req_valid),
        .cdp2mcif_rd_req_ready        (req_ready),
        .cdp2mcif_rd_req_pd           (req_pd),
        .mcif2cdp_rd_rsp_valid        (rsp_valid),
        .mcif2cdp_rd_rsp_ready        (rsp_ready),
        .mcif2cdp_rd_rsp_pd           (rsp_pd),
        .cdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .mem_rd_en                    (mem_rd_en),
        .mem_rd_addr                  (mem_rd_addr),
        .mem_rd_data                  (mem_rd_data),
        .cdt_overflow                 (cdt_overflow)
    );

    function automatic logic [255:0] pat(input logic [26:0] a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {a, 5'(k)} ^ 32'hC3A5_0F1E;
        return r;
    endfunction

    // Synchronous memory model: data is only meaningful one cycle after the strobe
    always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_rd_addr) : {8{$urandom}};

    // Optional client that returns one credit per accepted response
    always @(posedge clk) hs_d <= rsp_valid & rsp_ready;
    assign cdt_pop = auto_pop ? hs_d : man_pop;

    task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor and credit/overflow model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("credits", dut.credits, exp_credits);
            chk("cdt_overflow", cdt_overflow, exp_ovf);
            if (exp_credits == 0) chk("rsp_valid_no_credit", rsp_valid, 0);
            if (mem_rd_en) begin
                n_rd++;
                chk("rd_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) chk("mem_rd_addr", mem_rd_addr, exp_addr_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                chk("rsp_expected", exp_rsp_q.size() != 0, 1);
                if (exp_rsp_q.size() != 0) chk("rsp_pd", rsp_pd, exp_rsp_q.pop_front());
            end
            if (rsp_valid && rsp_ready && !cdt_pop) begin
                exp_credits--;
            end else if (!(rsp_valid && rsp_ready) && cdt_pop) begin
                if (exp_credits == 8) exp_ovf = 1'b1;
                else                  exp_credits++;
            end
        end
    end

    task automatic clear_model();
        exp_addr_q.delete();
        exp_rsp_q.delete();
        exp_credits = 8;
        exp_ovf     = 1'b0;
        n_rd        = 0;
        n_rsp       = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; man_pop = 1'b0; auto_pop = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [14:0] size);
        logic [26:0] a;
        bit ok;
        a  = addr[31:5];
        ok = 1'b0;
        for (int i = 0; i <= int'(size); i++) begin
            exp_addr_q.push_back(a + 27'(i));
            exp_rsp_q.push_back({1'b1, pat(a + 27'(i))});
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pd    = {size, addr};
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_accept", ok, 1);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (exp_rsp_q.size() == 0 && exp_addr_q.size() == 0 && req_ready) begin done = 1'b1; break; end
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_rsp_valid(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pd = '0; rsp_ready = 1'b0; man_pop = 1'b0; auto_pop = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_overflow", cdt_overflow, 0);
        chk("rst_credits", dut.credits, 8);
        rst = 1'b0;

        // Single atom: latency and address shift
        rsp_ready = 1'b1;
        send_req(32'h0000_1000, 15'd0);
        @(negedge clk);
        chk("t1_rd_en_c1", mem_rd_en, 1);
        chk("t1_rd_addr", mem_rd_addr, 27'h80);
        chk("t1_req_ready_c1", req_ready, 0);
        @(negedge clk);
        chk("t1_rd_en_c2", mem_rd_en, 0);
        chk("t1_rsp_valid_c2", rsp_valid, 0);
        chk("t1_req_ready_c2", req_ready, 1);
        @(negedge clk);
        chk("t1_rsp_valid_c3", rsp_valid, 1);
        chk("t1_rsp_pd", rsp_pd, {1'b1, pat(27'h80)});
        @(negedge clk);
        chk("t1_credits", dut.credits, 7);
        chk("t1_n_rd", n_rd, 1);
        chk("t1_n_rsp", n_rsp, 1);

        // Ten-atom burst with credits returned
        apply_reset();
        rsp_ready = 1'b1; auto_pop = 1'b1;
        send_req(32'h0000_0020, 15'd9);
        wait_drain(300, "t2_drain");
        repeat (3) @(negedge clk);
        chk("t2_n_rd", n_rd, 10);
        chk("t2_n_rsp", n_rsp, 10);
        chk("t2_credits", dut.credits, 8);

        // Response back-pressure with address wrap at the top of memory
        apply_reset();
        send_req(32'hFFFF_FFE0, 15'd15);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("t3_hold_valid", rsp_valid, 1);
                chk("t3_hold_pd", rsp_pd, {1'b1, pat(27'h7FF_FFFF)});
            end
        end
        chk("t3_n_rd_stalled", n_rd, 4);
        chk("t3_n_rsp_stalled", n_rsp, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1; auto_pop = 1'b1;
        wait_drain(400, "t3_drain");
        repeat (3) @(negedge clk);
        chk("t3_n_rd", n_rd, 16);
        chk("t3_n_rsp", n_rsp, 16);

        // Credit exhaustion: each pop releases exactly one response
        apply_reset();
        rsp_ready = 1'b1;
        send_req(32'h0000_8000, 15'd11);
        repeat (40) @(negedge clk);
        chk("t4_n_rsp_blocked", n_rsp, 8);
        chk("t4_rsp_valid_blocked", rsp_valid, 0);
        chk("t4_n_rd", n_rd, 12);
        chk("t4_credits_zero", dut.credits, 0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1 man_pop = 1'b1;
            @(posedge clk); #1 man_pop = 1'b0;
            repeat (4) @(negedge clk);
            chk("t4_n_rsp_step", n_rsp, 9 + j);
            chk("t4_rsp_valid_step", rsp_valid, 0);
        end
        chk("t4_queue_empty", exp_rsp_q.size(), 0);

        // Simultaneous pop+handshake at full credit, then overflow
        apply_reset();
        send_req(32'h0000_3000, 15'd0);
        wait_rsp_valid(20, "t5_rsp_valid");
        @(posedge clk); #1 man_pop = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1 man_pop = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("t5_same_cycle_credits", dut.credits, 8);
        chk("t5_same_cycle_ovf", cdt_overflow, 0);
        chk("t5_n_rsp", n_rsp, 1);
        @(posedge clk); #1 man_pop = 1'b1;
        @(posedge clk); #1 man_pop = 1'b0;
        @(negedge clk);
        chk("t5_ovf_set", cdt_overflow, 1);
        chk("t5_ovf_credits", dut.credits, 8);
        rsp_ready = 1'b1; auto_pop = 1'b1;
        send_req(32'h0000_3400, 15'd2);
        wait_drain(100, "t5_drain");
        repeat (3) @(negedge clk);
        chk("t5_ovf_sticky", cdt_overflow, 1);

        // Reset in the middle of a burst
        apply_reset();
        rsp_ready = 1'b1; auto_pop = 1'b1;
        send_req(32'h0000_0400, 15'd7);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk); #1;
                if (n_rd >= 3) begin hit = 1'b1; break; end
            end
            chk("t6_three_reads", hit, 1);
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_req_ready", req_ready, 1);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_mem_rd_en", mem_rd_en, 0);
        chk("t6_rst_overflow", cdt_overflow, 0);
        chk("t6_rst_credits", dut.credits, 8);
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_post_rsp_valid", rsp_valid, 0);
            chk("t6_post_mem_rd_en", mem_rd_en, 0);
        end
        send_req(32'h0000_2013, 15'd0);
        wait_drain(50, "t6_drain");
        repeat (3) @(negedge clk);
        chk("t6_n_rd", n_rd, 1);
        chk("t6_n_rsp", n_rsp, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
